// File: rtl/mpmod_addsub_ctrl.sv
// mpmod_addsub_ctrl: sequences one or two mpadder operations to form (a+b) mod M or (a-b) mod M
//
// Ports:
//    i_clk, i_resetn              clock, asynchronous active-low reset
//    i_start                      1-cycle request, sampled only in IDLE
//    i_subtract                   0: a+b mod M, 1: a-b mod M
//    i_in_a, i_in_b, i_in_m       operands (a,b < M) and modulus M
//    o_result, o_done             reduced result, 1-cycle completion pulse
//    o_add_start, o_add_subtract  mpadder start pulse and mode
//    o_add_in_a, o_add_in_b       mpadder operands
//    i_add_result, i_add_done     mpadder WIDTH+1 bit result (top bit carry/borrow) and done
//
// Option: MPMOD_EARLY_EXIT_EN lets a subtraction that did not borrow finish after one mpadder pass.
module mpmod_addsub_ctrl #(
   parameter int WIDTH = 1027
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_start,
   input  logic             i_subtract,
   input  logic [WIDTH-1:0] i_in_a,
   input  logic [WIDTH-1:0] i_in_b,
   input  logic [WIDTH-1:0] i_in_m,
   output logic [WIDTH-1:0] o_result,
   output logic             o_done,
   output logic             o_add_start,
   output logic             o_add_subtract,
   output logic [WIDTH-1:0] o_add_in_a,
   output logic [WIDTH-1:0] o_add_in_b,
   input  logic [WIDTH:0]   i_add_result,
   input  logic             i_add_done
);
   typedef enum logic [2:0] {S_IDLE, S_OP1, S_WAIT1, S_OP2, S_WAIT2, S_DONE} state_t;
   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_m, w_m;
   logic             r_sub, w_sub;
   logic [WIDTH:0]   r_r1, w_r1;
   logic [WIDTH-1:0] r_result, w_result;
   logic             r_done, w_done;
   logic             r_add_start, w_add_start;
   logic             r_add_sub, w_add_sub;
   logic [WIDTH-1:0] r_add_in_a, w_add_in_a;
   logic [WIDTH-1:0] r_add_in_b, w_add_in_b;
   logic             w_early;
   logic [WIDTH-1:0] w_sel;
`ifdef MPMOD_EARLY_EXIT_EN
   // a-b without borrow is already in range, so the correction pass is skipped
   assign w_early = r_sub & ~i_add_result[WIDTH];
`else
   assign w_early = 1'b0;
`endif
   // add: keep r1-M unless it borrowed; sub: keep r1+M only if a-b borrowed
   assign w_sel = r_sub ? (r_r1[WIDTH] ? i_add_result[WIDTH-1:0] : r_r1[WIDTH-1:0])
                        : (i_add_result[WIDTH] ? r_r1[WIDTH-1:0] : i_add_result[WIDTH-1:0]);
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state     <= S_IDLE;
         r_m         <= '0;
         r_sub       <= 1'b0;
         r_r1        <= '0;
         r_result    <= '0;
         r_done      <= 1'b0;
         r_add_start <= 1'b0;
         r_add_sub   <= 1'b0;
         r_add_in_a  <= '0;
         r_add_in_b  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_m         <= w_m;
         r_sub       <= w_sub;
         r_r1        <= w_r1;
         r_result    <= w_result;
         r_done      <= w_done;
         r_add_start <= w_add_start;
         r_add_sub   <= w_add_sub;
         r_add_in_a  <= w_add_in_a;
         r_add_in_b  <= w_add_in_b;
      end
   end
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = i_start ? S_OP1 : S_IDLE;
         S_OP1:   w_state_nxt = S_WAIT1;
         S_WAIT1: w_state_nxt = !i_add_done ? S_WAIT1 : (w_early ? S_DONE : S_OP2);
         S_OP2:   w_state_nxt = S_WAIT2;
         S_WAIT2: w_state_nxt = i_add_done ? S_DONE : S_WAIT2;
         default: w_state_nxt = S_IDLE;
      endcase
   end
   // Next values of the registered outputs: they are loaded on the edge that enters
   // OP1/OP2/DONE so that start/done are high exactly while in those states.
   always_comb begin
      w_m         = r_m;
      w_sub       = r_sub;
      w_r1        = r_r1;
      w_result    = r_result;
      w_done      = 1'b0;
      w_add_start = 1'b0;
      w_add_sub   = r_add_sub;
      w_add_in_a  = r_add_in_a;
      w_add_in_b  = r_add_in_b;
      case (r_state)
         S_IDLE: if (i_start) begin
            w_m         = i_in_m;
            w_sub       = i_subtract;
            w_add_start = 1'b1;
            w_add_sub   = i_subtract;
            w_add_in_a  = i_in_a;
            w_add_in_b  = i_in_b;
         end
         S_WAIT1: if (i_add_done) begin
            w_r1 = i_add_result;
            if (w_early) begin
               w_result = i_add_result[WIDTH-1:0];
               w_done   = 1'b1;
            end else begin
               w_add_start = 1'b1;
               w_add_sub   = ~r_sub;
               w_add_in_a  = i_add_result[WIDTH-1:0];
               w_add_in_b  = r_m;
            end
         end
         S_WAIT2: if (i_add_done) begin
            w_result = w_sel;
            w_done   = 1'b1;
         end
         default: ;
      endcase
   end
   assign o_result       = r_result;
   assign o_done         = r_done;
   assign o_add_start    = r_add_start;
   assign o_add_subtract = r_add_sub;
   assign o_add_in_a     = r_add_in_a;
   assign o_add_in_b     = r_add_in_b;
endmodule

// File: tb/tb_mpmod_addsub_ctrl.sv
// tb_mpmod_addsub_ctrl: directed vectors against a behavioural mpadder with configurable done latency
module tb_mpmod_addsub_ctrl;
   localparam int W = 1027;
   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         i_start = 1'b0;
   logic         i_sub = 1'b0;
   logic [W-1:0] i_a = '0, i_b = '0, i_m = '0;
   logic [W-1:0] o_result, o_add_in_a, o_add_in_b;
   logic         o_done, o_add_start, o_add_sub;
   logic [W:0]   add_result = '0;
   logic         add_done = 1'b0;
   int           n_checks = 0, n_fail = 0, n_starts = 0, dly = 1, cnt = 0, c;
   mpmod_addsub_ctrl #(.WIDTH(W)) dut (
      .i_clk(clk), .i_resetn(resetn), .i_start(i_start), .i_subtract(i_sub),
      .i_in_a(i_a), .i_in_b(i_b), .i_in_m(i_m),
      .o_result(o_result), .o_done(o_done), .o_add_start(o_add_start),
      .o_add_subtract(o_add_sub), .o_add_in_a(o_add_in_a), .o_add_in_b(o_add_in_b),
      .i_add_result(add_result), .i_add_done(add_done)
   );
   always #5 clk = ~clk;
   // mpadder model: result latched on start, done pulses dly cycles later
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= 0;
         add_done <= 1'b0;
      end else begin
         if (o_add_start) begin
            n_starts <= n_starts + 1;
            add_result <= o_add_sub ? {1'b0, o_add_in_a} - {1'b0, o_add_in_b}
                                    : {1'b0, o_add_in_a} + {1'b0, o_add_in_b};
         end
         c = o_add_start ? dly : (cnt > 0 ? cnt - 1 : 0);
         cnt <= c;
         add_done <= (c == 1);
      end
   end
   task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_zero(input string tag);
      check({tag, "/result"}, {1'b0, o_result}, 0);
      check({tag, "/done"}, {{W{1'b0}}, o_done}, 0);
      check({tag, "/add_start"}, {{W{1'b0}}, o_add_start}, 0);
      check({tag, "/add_sub"}, {{W{1'b0}}, o_add_sub}, 0);
      check({tag, "/add_in_a"}, {1'b0, o_add_in_a}, 0);
      check({tag, "/add_in_b"}, {1'b0, o_add_in_b}, 0);
   endtask
   task automatic run_op(input string tag, input logic sub, input int a, input int b, input int m,
                         input int exp_r, input bit glitch);
      int cyc, exp_cyc, exp_st, extra_done;
      bit seen;
      exp_cyc = 5 + 2 * (dly - 1);
      exp_st = 2;
`ifdef MPMOD_EARLY_EXIT_EN
      if (sub && a >= b) begin
         exp_cyc = 3 + (dly - 1);
         exp_st = 1;
      end
`endif
      @(negedge clk);
      i_start = 1'b1; i_sub = sub; i_a = W'(a); i_b = W'(b); i_m = W'(m);
      n_starts = 0;
      @(posedge clk);
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         seen = o_done;
         i_start = glitch && (cyc == 2 || seen);
         if (i_start) begin
            i_a = W'(1); i_b = W'(2);
         end
      end
      check({tag, "/done_seen"}, {{W{1'b0}}, seen}, 1);
      check({tag, "/done_cycle"}, (W+1)'(cyc), (W+1)'(exp_cyc));
      check({tag, "/result"}, {1'b0, o_result}, (W+1)'(exp_r));
      check({tag, "/add_starts"}, (W+1)'(n_starts), (W+1)'(exp_st));
      @(negedge clk);
      i_start = 1'b0;
      check({tag, "/done_pulse"}, {{W{1'b0}}, o_done}, 0);
      if (glitch) begin
         extra_done = 0;
         repeat (8) begin
            @(negedge clk);
            if (o_done) extra_done++;
         end
         check({tag, "/extra_done"}, (W+1)'(extra_done), 0);
         check({tag, "/extra_starts"}, (W+1)'(n_starts), (W+1)'(exp_st));
         check({tag, "/held_result"}, {1'b0, o_result}, (W+1)'(exp_r));
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset");
      resetn = 1'b1;
      run_op("add_7_9", 1'b0, 7, 9, 13, 3, 1'b0);
      run_op("add_5_8", 1'b0, 5, 8, 13, 0, 1'b0);
      run_op("add_2_3", 1'b0, 2, 3, 13, 5, 1'b0);
      run_op("add_12_12", 1'b0, 12, 12, 13, 11, 1'b0);
      run_op("sub_3_9", 1'b1, 3, 9, 13, 7, 1'b0);
      run_op("sub_9_9", 1'b1, 9, 9, 13, 0, 1'b0);
      run_op("sub_10_4", 1'b1, 10, 4, 13, 6, 1'b0);
      run_op("sub_0_12", 1'b1, 0, 12, 13, 1, 1'b0);
      run_op("restart", 1'b0, 7, 9, 13, 3, 1'b1);
      @(negedge clk);
      i_start = 1'b1; i_sub = 1'b0; i_a = W'(11); i_b = W'(6); i_m = W'(13);
      @(posedge clk);
      repeat (4) @(negedge clk);
      i_start = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      resetn = 1'b1;
      run_op("after_reset", 1'b0, 11, 6, 13, 4, 1'b0);
      dly = 4;
      run_op("slow_add", 1'b0, 7, 9, 13, 3, 1'b0);
      run_op("slow_sub", 1'b1, 3, 9, 13, 7, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
